// File: rtl/qeciphy_crc_check.sv
// Receive-side CRC checker: pairs the received CRC word of each window with the
// locally computed CRCs, reports pass/fail, counts failures and tracks CRC lock.
module qeciphy_crc_check #(
  parameter int GOOD_THRESHOLD = 4,
  parameter int BAD_THRESHOLD  = 2,
  parameter int ERR_CNT_W      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic                 crc_boundary_i,
  input  logic [63:0]          tdata_i,
  input  logic [15:0]          crc01_i,
  input  logic [15:0]          crc23_i,
  input  logic [15:0]          crc45_i,
  input  logic [7:0]           crcvw_i,
  input  logic                 crc_valid_i,
  input  logic                 clr_count_i,
  output logic                 crc_ok_o,
  output logic                 crc_error_o,
  output logic [3:0]           error_mask_o,
  output logic [ERR_CNT_W-1:0] err_count_o,
  output logic                 link_locked_o,
  output logic                 seq_error_o
);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  localparam logic [3:0]           GOOD_TH = 4'(GOOD_THRESHOLD);
  localparam logic [3:0]           BAD_TH  = 4'(BAD_THRESHOLD);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  // Field layout of both holding registers: {vw, crc45, crc23, crc01}.
  logic [55:0] rx_q;
  logic [55:0] calc_q;
  logic        rx_pend;
  logic        calc_pend;
  logic        rx_cap;
  logic        calc_cap;
  logic        compare;
  logic        pass;
  logic        fail;
  logic [3:0]  mismatch;
  logic [0:0]  state;
  logic [3:0]  good_cnt;
  logic [3:0]  bad_cnt;
  logic        unused_tdata;

  assign unused_tdata = &{1'b0, tdata_i[63:56]};

  assign rx_cap   = enable_i & crc_boundary_i;
  assign calc_cap = enable_i & crc_valid_i;
  assign compare  = enable_i & rx_pend & calc_pend;

  assign mismatch[0] = rx_q[15:0]  != calc_q[15:0];
  assign mismatch[1] = rx_q[31:16] != calc_q[31:16];
  assign mismatch[2] = rx_q[47:32] != calc_q[47:32];
  assign mismatch[3] = rx_q[55:48] != calc_q[55:48];

  assign pass = compare & ~|mismatch;
  assign fail = compare &  |mismatch;

  // A capture on the consuming edge keeps its pend flag set: the new word
  // belongs to the next pair, so set-priority over clear is intentional.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst_n_i) begin
      rx_q        <= '0;
      calc_q      <= '0;
      rx_pend     <= 1'b0;
      calc_pend   <= 1'b0;
      seq_error_o <= 1'b0;
    end else if (!enable_i) begin
      rx_pend     <= 1'b0;
      calc_pend   <= 1'b0;
      seq_error_o <= 1'b0;
    end else begin
      if (rx_cap)   rx_q   <= tdata_i[55:0];
      if (calc_cap) calc_q <= {crcvw_i, crc45_i, crc23_i, crc01_i};
      rx_pend   <= rx_cap   | (rx_pend   & ~compare);
      calc_pend <= calc_cap | (calc_pend & ~compare);
      if ((rx_cap & rx_pend & ~compare) | (calc_cap & calc_pend & ~compare))
        seq_error_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      crc_ok_o     <= 1'b0;
      crc_error_o  <= 1'b0;
      error_mask_o <= '0;
      err_count_o  <= '0;
    end else begin
      crc_ok_o    <= pass;
      crc_error_o <= fail;
      if (compare) error_mask_o <= mismatch;
      // A clear coinciding with a failure still records that failure.
      if (clr_count_i)
        err_count_o <= fail ? ERR_CNT_W'(1) : '0;
      else if (fail && err_count_o != CNT_MAX)
        err_count_o <= err_count_o + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= ST_UNLOCKED;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (!enable_i) begin
      state    <= ST_UNLOCKED;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (compare) begin
      if (state == ST_UNLOCKED) begin
        if (pass) begin
          if (good_cnt + 4'd1 == GOOD_TH) begin
            state    <= ST_LOCKED;
            good_cnt <= '0;
            bad_cnt  <= '0;
          end else begin
            good_cnt <= good_cnt + 4'd1;
          end
        end else begin
          good_cnt <= '0;
        end
      end else begin
        if (fail) begin
          if (bad_cnt + 4'd1 == BAD_TH) begin
            state    <= ST_UNLOCKED;
            good_cnt <= '0;
            bad_cnt  <= '0;
          end else begin
            bad_cnt <= bad_cnt + 4'd1;
          end
        end else begin
          bad_cnt <= '0;
        end
      end
    end
  end

  assign link_locked_o = (state == ST_LOCKED);

endmodule

// File: tb/tb_qeciphy_crc_check.sv
// Self-checking bench for qeciphy_crc_check: table vectors, hand-written corner
// sequences and randomized pairs against a history-based reference model.
module tb_qeciphy_crc_check;

  localparam int GOOD = 4;
  localparam int BAD  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        boundary = 1'b0;
  logic        valid = 1'b0;
  logic        clr = 1'b0;
  logic [63:0] tdata = '0;
  logic [15:0] c01 = '0, c23 = '0, c45 = '0;
  logic [7:0]  cvw = '0;

  logic        ok_a, err_a, lock_a, seq_a;
  logic [3:0]  mask_a;
  logic [15:0] cnt_a;
  logic        ok_b, err_b, lock_b, seq_b;
  logic [3:0]  mask_b;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  qeciphy_crc_check #(.GOOD_THRESHOLD(GOOD), .BAD_THRESHOLD(BAD), .ERR_CNT_W(16)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .crc_boundary_i(boundary),
    .tdata_i(tdata), .crc01_i(c01), .crc23_i(c23), .crc45_i(c45), .crcvw_i(cvw),
    .crc_valid_i(valid), .clr_count_i(clr), .crc_ok_o(ok_a), .crc_error_o(err_a),
    .error_mask_o(mask_a), .err_count_o(cnt_a), .link_locked_o(lock_a), .seq_error_o(seq_a));

  qeciphy_crc_check #(.GOOD_THRESHOLD(GOOD), .BAD_THRESHOLD(BAD), .ERR_CNT_W(2)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .crc_boundary_i(boundary),
    .tdata_i(tdata), .crc01_i(c01), .crc23_i(c23), .crc45_i(c45), .crcvw_i(cvw),
    .crc_valid_i(valid), .clr_count_i(clr), .crc_ok_o(ok_b), .crc_error_o(err_b),
    .error_mask_o(mask_b), .err_count_o(cnt_b), .link_locked_o(lock_b), .seq_error_o(seq_b));

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: pass/fail history since the last flush, counters, flags.
  bit         hist[$];
  int         exp_cnt16 = 0;
  int         exp_cnt2 = 0;
  logic [3:0] exp_mask = '0;
  bit         exp_seq = 1'b0;

  localparam logic [55:0] BASE = {8'hDE, 16'h9ABC, 16'h5678, 16'h1234};

  typedef struct {
    logic [55:0] flip;
    logic [7:0]  top;
    int          d;
    logic [3:0]  mask;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    check(name, {28'd0, ok_a, err_a, ok_b, err_b}, 32'd0);
  endtask

  task automatic drive_rx(input logic [63:0] w);
    boundary = 1'b1;
    tdata    = w;
  endtask

  task automatic drive_calc(input logic [55:0] c);
    valid = 1'b1;
    {cvw, c45, c23, c01} = c;
  endtask

  // Garbage on the data buses whenever the strobes are low: it must not be captured.
  task automatic clear_inputs();
    boundary = 1'b0;
    valid    = 1'b0;
    tdata    = {$urandom, $urandom};
    {cvw, c45, c23, c01} = {$urandom, $urandom};
  endtask

  function automatic logic [3:0] field_mask(input logic [55:0] r, input logic [55:0] c);
    return {r[55:48] != c[55:48], r[47:32] != c[47:32],
            r[31:16] != c[31:16], r[15:0]  != c[15:0]};
  endfunction

  // Lock state from the history: toggle whenever the run of "state-breaking"
  // results (passes when unlocked, fails when locked) reaches its threshold.
  function automatic bit lock_model();
    bit locked = 1'b0;
    int run = 0;
    foreach (hist[i]) begin
      if (hist[i] == !locked) run++;
      else run = 0;
      if (run == (locked ? BAD : GOOD)) begin
        locked = !locked;
        run = 0;
      end
    end
    return locked;
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_cnt16 = 0;
    exp_cnt2  = 0;
    exp_mask  = '0;
    exp_seq   = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_pulses"}, {28'd0, ok_a, err_a, ok_b, err_b}, 32'd0);
    check({name, "_mask"},   {24'd0, mask_a, mask_b}, 32'd0);
    check({name, "_count"},  {14'd0, cnt_a, cnt_b}, 32'd0);
    check({name, "_flags"},  {28'd0, lock_a, seq_a, lock_b, seq_b}, 32'd0);
  endtask

  // Called right after edge E (the later capture); checks E+1 result and pulse width.
  task automatic finish_pair(input logic [3:0] mask, input bit clr_at_result);
    bit pass = (mask == 4'd0);
    check_idle("pre_result");
    clr = clr_at_result;
    tick();
    clr = 1'b0;
    if (!pass) begin
      exp_cnt16 = clr_at_result ? 1 : (exp_cnt16 == 65535 ? 65535 : exp_cnt16 + 1);
      exp_cnt2  = clr_at_result ? 1 : (exp_cnt2 == 3 ? 3 : exp_cnt2 + 1);
    end else if (clr_at_result) begin
      exp_cnt16 = 0;
      exp_cnt2  = 0;
    end
    exp_mask = mask;
    hist.push_back(pass);
    check("result_ok",  {30'd0, ok_a, ok_b},   {30'd0, pass, pass});
    check("result_err", {30'd0, err_a, err_b}, {30'd0, !pass, !pass});
    check("mask",       {28'd0, mask_a},       {28'd0, exp_mask});
    check("count16",    {16'd0, cnt_a},        exp_cnt16);
    check("count2",     {30'd0, cnt_b},        exp_cnt2);
    check("locked",     {31'd0, lock_a},       {31'd0, lock_model()});
    check("seq_error",  {31'd0, seq_a},        {31'd0, exp_seq});
    tick();
    check_idle("pulse_width");
    check("mask_hold",  {28'd0, mask_a},       {28'd0, exp_mask});
  endtask

  // d > 0: computed CRCs d cycles before the RX word; d < 0: the reverse; 0: same edge.
  task automatic do_pair(input logic [63:0] rx, input logic [55:0] calc, input int d,
                         input logic [3:0] mask, input bit clr_at_result);
    int gap = (d < 0) ? -d : d;
    if (d == 0) begin
      drive_rx(rx);
      drive_calc(calc);
      tick();
      clear_inputs();
    end else begin
      if (d > 0) drive_calc(calc);
      else       drive_rx(rx);
      tick();
      clear_inputs();
      for (int i = 1; i < gap; i++) begin
        check_idle("gap");
        tick();
      end
      if (d > 0) drive_rx(rx);
      else       drive_calc(calc);
      tick();
      clear_inputs();
    end
    finish_pair(mask, clr_at_result);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{56'h0,                                 8'h00,  0, 4'b0000};
    tbl[1] = '{{8'h00, 16'h0000, 16'h0001, 16'h0000}, 8'h00,  0, 4'b0010};
    tbl[2] = '{56'h0,                                 8'h00,  3, 4'b0000};
    tbl[3] = '{56'h0,                                 8'h00, -3, 4'b0000};
    tbl[4] = '{56'h0,                                 8'hFF,  1, 4'b0000};
    tbl[5] = '{{8'h00, 16'h0000, 16'h0000, 16'h8000}, 8'h00, -1, 4'b0001};
    tbl[6] = '{{8'h00, 16'h0100, 16'h0000, 16'h0000}, 8'h00,  2, 4'b0100};
    tbl[7] = '{{8'h01, 16'h0000, 16'h0000, 16'h0000}, 8'h00,  0, 4'b1000};
    tbl[8] = '{{8'hFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 8'h5A, -2, 4'b1111};
    tbl[9] = '{{8'h80, 16'h0000, 16'h0000, 16'h0001}, 8'h00,  0, 4'b1001};

    // Reset state.
    #2;
    check_all_zero("reset_init");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_all_zero("after_release");

    // Table vectors: match/mismatch per field, orderings, ignored top byte, saturation.
    foreach (tbl[i])
      do_pair({tbl[i].top, BASE ^ tbl[i].flip}, BASE, tbl[i].d, tbl[i].mask, 1'b0);

    // Lock / unlock.
    for (int i = 0; i < 3; i++) do_pair({8'h00, BASE}, BASE, 0, 4'b0000, 1'b0);
    check("lock_after_3", {31'd0, lock_a}, 32'd0);
    do_pair({8'h00, BASE}, BASE, 0, 4'b0000, 1'b0);
    check("lock_after_4", {31'd0, lock_a}, 32'd1);
    do_pair({8'h00, BASE ^ 56'h1}, BASE, 0, 4'b0001, 1'b0);
    do_pair({8'h00, BASE}, BASE, 0, 4'b0000, 1'b0);
    do_pair({8'h00, BASE ^ 56'h1}, BASE, 0, 4'b0001, 1'b0);
    check("lock_held", {31'd0, lock_a}, 32'd1);
    do_pair({8'h00, BASE ^ 56'h1}, BASE, 0, 4'b0001, 1'b0);
    check("unlock", {31'd0, lock_a}, 32'd0);

    // Fail coinciding with a count clear.
    do_pair({8'h00, BASE ^ 56'h10000}, BASE, 0, 4'b0010, 1'b1);
    check("clr_fail16", {16'd0, cnt_a}, 32'd1);
    check("clr_fail2",  {30'd0, cnt_b}, 32'd1);

    // Pairing fault: two RX words without a computed CRC in between.
    drive_rx({8'h00, ~BASE});
    tick();
    clear_inputs();
    check_idle("fault_gap");
    drive_rx({8'h00, BASE});
    tick();
    clear_inputs();
    exp_seq = 1'b1;
    check("seq_set", {31'd0, seq_a}, 32'd1);
    tick();
    check("seq_sticky", {31'd0, seq_a}, 32'd1);
    drive_calc(BASE);
    tick();
    clear_inputs();
    finish_pair(4'b0000, 1'b0);

    // Drop enable while locked: flushes FSM and seq_error, holds count and mask.
    for (int i = 0; i < 4; i++) do_pair({8'h00, BASE}, BASE, 0, 4'b0000, 1'b0);
    check("locked_pre_disable", {31'd0, lock_a}, 32'd1);
    enable = 1'b0;
    drive_rx({8'h00, ~BASE});
    tick();
    clear_inputs();
    exp_seq = 1'b0;
    hist.delete();
    check("dis_locked",  {31'd0, lock_a}, 32'd0);
    check("dis_seq",     {31'd0, seq_a},  32'd0);
    check("dis_count",   {16'd0, cnt_a},  exp_cnt16);
    check("dis_mask",    {28'd0, mask_a}, {28'd0, exp_mask});
    tick();
    enable = 1'b1;
    do_pair({8'h00, BASE}, BASE, 2, 4'b0000, 1'b0);

    // Reset between RX capture and computed CRC: the lone CRC gives no result.
    drive_rx({8'h00, BASE ^ 56'h3});
    tick();
    clear_inputs();
    apply_reset();
    drive_calc(BASE);
    tick();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      check_idle("lone_calc");
      tick();
    end
    apply_reset();
    tick();

    // Randomized pairs against the model.
    for (int n = 0; n < 40; n++) begin
      logic [55:0] calc;
      logic [55:0] flip;
      int d;
      calc = {$urandom, $urandom};
      flip = '0;
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 2) == 0) flip[15:0]  = 16'($urandom_range(1, 65535));
        if ($urandom_range(0, 2) == 0) flip[31:16] = 16'($urandom_range(1, 65535));
        if ($urandom_range(0, 2) == 0) flip[47:32] = 16'($urandom_range(1, 65535));
        if ($urandom_range(0, 2) == 0) flip[55:48] = 8'($urandom_range(1, 255));
      end
      d = int'($urandom_range(0, 8)) - 4;
      do_pair({8'($urandom), calc ^ flip}, calc, d, field_mask(calc ^ flip, calc),
              $urandom_range(0, 7) == 0);
      for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
        check_idle("rand_idle");
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
